// File: rtl/tour_pkg.sv
// -----------------------------------------------------------------------------
// tour_pkg
// Shared types and constants for the knight tour command sequencer.
//   state_t    : sequencer FSM states
//   MOVE/MOVE_FF/ABORT : command opcodes (upper nibble of a 16-bit command)
//   NORTH/WEST/SOUTH/EAST : heading bytes
//   ACK/PROG   : response bytes
//   LAST_MOVE  : index of the final solved move
// -----------------------------------------------------------------------------
package tour_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        HOLD_V,
        HORZ,
        HOLD_H
    } state_t;

    localparam logic [3:0] MOVE    = 4'b0010;
    localparam logic [3:0] MOVE_FF = 4'b0011;
    localparam logic [3:0] ABORT   = 4'hF;

    localparam logic [7:0] NORTH = 8'h00;
    localparam logic [7:0] WEST  = 8'h3F;
    localparam logic [7:0] SOUTH = 8'h7F;
    localparam logic [7:0] EAST  = 8'hBF;

    localparam logic [7:0] ACK  = 8'hA5;
    localparam logic [7:0] PROG = 8'h5A;

    localparam logic [4:0] LAST_MOVE = 5'd23;

    // Packs a cmd_proc command word: {opcode, heading, squares}.
    function automatic logic [15:0] make_cmd(input logic [3:0] op,
                                             input logic [7:0] hdg,
                                             input logic [3:0] sq);
        return {op, hdg, sq};
    endfunction

endpackage

// File: rtl/tour_move_decode.sv
// -----------------------------------------------------------------------------
// tour_move_decode
// Combinational lookup from a one-hot knight move to its two straight legs.
// Ports:
//   move     in  8 : one-hot move (bit n = move n of the solver encoding)
//   vert_hdg out 8 : heading of the vertical leg (NORTH or SOUTH)
//   vert_sq  out 4 : squares of the vertical leg (1 or 2)
//   horz_hdg out 8 : heading of the horizontal leg (EAST or WEST)
//   horz_sq  out 4 : squares of the horizontal leg (1 or 2)
// -----------------------------------------------------------------------------
module tour_move_decode
    import tour_pkg::*;
(
    input  logic [7:0] move,
    output logic [7:0] vert_hdg,
    output logic [3:0] vert_sq,
    output logic [7:0] horz_hdg,
    output logic [3:0] horz_sq
);

    always_comb begin
        // Zero or multi-hot moves never occur; the default just keeps the
        // outputs defined.
        vert_hdg = NORTH;
        vert_sq  = 4'd1;
        horz_hdg = EAST;
        horz_sq  = 4'd1;
        case (move)
            8'h01: begin vert_hdg = NORTH; vert_sq = 4'd2; horz_hdg = EAST; horz_sq = 4'd1; end
            8'h02: begin vert_hdg = NORTH; vert_sq = 4'd2; horz_hdg = WEST; horz_sq = 4'd1; end
            8'h04: begin vert_hdg = NORTH; vert_sq = 4'd1; horz_hdg = WEST; horz_sq = 4'd2; end
            8'h08: begin vert_hdg = SOUTH; vert_sq = 4'd1; horz_hdg = WEST; horz_sq = 4'd2; end
            8'h10: begin vert_hdg = SOUTH; vert_sq = 4'd2; horz_hdg = WEST; horz_sq = 4'd1; end
            8'h20: begin vert_hdg = SOUTH; vert_sq = 4'd2; horz_hdg = EAST; horz_sq = 4'd1; end
            8'h40: begin vert_hdg = SOUTH; vert_sq = 4'd1; horz_hdg = EAST; horz_sq = 4'd2; end
            8'h80: begin vert_hdg = NORTH; vert_sq = 4'd1; horz_hdg = EAST; horz_sq = 4'd2; end
            default: ;
        endcase
    end

endmodule

// File: rtl/tour_sequencer.sv
// -----------------------------------------------------------------------------
// tour_sequencer
// Sits between the tour solver, the UART command wrapper and cmd_proc. Idle:
// UART commands pass straight through. After start_tour it plays the 24 solved
// moves, each as a vertical MOVE leg followed by a horizontal MOVE_FF leg.
//
// Optional feature (macro TOUR_SEQ_ABORT_EN): a UART command with opcode 4'hF
// received during a tour is acknowledged and aborts the tour back to IDLE.
//
// Ports:
//   clk               in   1 : system clock
//   rst               in   1 : synchronous active-high reset
//   start_tour        in   1 : solver pulse, solution ready
//   move              in   8 : one-hot move at mv_indx (combinational read)
//   mv_indx           out  5 : index of the move being played
//   cmd_UART          in  16 : command from UART wrapper
//   cmd_rdy_UART      in   1 : UART command valid
//   clr_cmd_rdy_UART  out  1 : UART command acknowledge
//   cmd               out 16 : command to cmd_proc
//   cmd_rdy           out  1 : cmd valid
//   clr_cmd_rdy       in   1 : cmd_proc accepted cmd
//   send_resp         in   1 : cmd_proc finished a command
//   resp              out  8 : response byte for the UART
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | UART pass-through, waiting for start_tour
// VERT   | vertical leg presented to cmd_proc, waiting for accept
// HOLD_V | vertical leg accepted, waiting for send_resp
// HORZ   | horizontal leg presented to cmd_proc, waiting for accept
// HOLD_H | horizontal leg accepted, waiting for send_resp, then next move
// -----------------------------------------------------------------------------
module tour_sequencer
    import tour_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    state_t     state;
    logic [4:0] idx;
    logic       abort;
    logic [7:0] vert_hdg;
    logic [3:0] vert_sq;
    logic [7:0] horz_hdg;
    logic [3:0] horz_sq;

    assign mv_indx = idx;

`ifdef TOUR_SEQ_ABORT_EN
    assign abort = (state != IDLE) && cmd_rdy_UART && (cmd_UART[15:12] == ABORT);
`else
    assign abort = 1'b0;
`endif

    tour_move_decode u_decode (
        .move     (move),
        .vert_hdg (vert_hdg),
        .vert_sq  (vert_sq),
        .horz_hdg (horz_hdg),
        .horz_sq  (horz_sq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 5'd0;
        end else if (abort) begin
            state <= IDLE;
            idx   <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_tour) begin
                        state <= VERT;
                        idx   <= 5'd0;
                    end
                end
                // send_resp is deliberately ignored while a leg is waiting
                // for acceptance; only the HOLD states react to it.
                VERT:   if (clr_cmd_rdy) state <= HOLD_V;
                HOLD_V: if (send_resp)   state <= HORZ;
                HORZ:   if (clr_cmd_rdy) state <= HOLD_H;
                HOLD_H: begin
                    if (send_resp) begin
                        if (idx == LAST_MOVE) begin
                            state <= IDLE;
                        end else begin
                            idx   <= idx + 5'd1;
                            state <= VERT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are combinational: pass-through and move decode must be
    // visible in the same cycle as their inputs.
    always_comb begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = ACK;
        if (state != IDLE) begin
            clr_cmd_rdy_UART = abort;
            cmd_rdy          = (state == VERT) || (state == HORZ);
            if ((state == VERT) || (state == HOLD_V))
                cmd = make_cmd(MOVE, vert_hdg, vert_sq);
            else
                cmd = make_cmd(MOVE_FF, horz_hdg, horz_sq);
            if (abort || ((state == HOLD_H) && send_resp && (idx == LAST_MOVE)))
                resp = ACK;
            else
                resp = PROG;
        end
    end

endmodule

// File: tb/tb_tour_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tour_sequencer
// Self-checking bench for tour_sequencer. A tour is modelled as 48 legs
// (leg n plays move n/2; even legs vertical, odd legs horizontal), each either
// waiting for acceptance or for completion. Leg commands are derived from the
// knight's (dy, dx) displacement. Honours TOUR_SEQ_ABORT_EN like the design.
// -----------------------------------------------------------------------------
module tb_tour_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_tour = 1'b0;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART = 16'h0000;
    logic        cmd_rdy_UART = 1'b0;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp;

    logic [7:0]  sol [24];

`ifdef TOUR_SEQ_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    tour_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .start_tour       (start_tour),
        .move             (move),
        .mv_indx          (mv_indx),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .send_resp        (send_resp),
        .resp             (resp)
    );

    // Solver memory read at whatever index the DUT presents.
    assign move = (mv_indx < 5'd24) ? sol[mv_indx] : 8'h01;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    bit m_active = 1'b0;
    int m_leg    = 0;
    bit m_wait   = 1'b1;

    int n_cmds  = 0;
    int max_idx = 0;

    logic [15:0] lit_tab [4];

    function automatic logic [15:0] leg_cmd(input logic [7:0] mv, input bit vert);
        int dy = 0;
        int dx = 0;
        for (int b = 0; b < 8; b++) begin
            if (mv[b]) begin
                case (b)
                    0: begin dy =  2; dx =  1; end
                    1: begin dy =  2; dx = -1; end
                    2: begin dy =  1; dx = -2; end
                    3: begin dy = -1; dx = -2; end
                    4: begin dy = -2; dx = -1; end
                    5: begin dy = -2; dx =  1; end
                    6: begin dy = -1; dx =  2; end
                    default: begin dy = 1; dx = 2; end
                endcase
            end
        end
        if (vert)
            return {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
        else
            return {4'h3, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit abort_now();
        return ABORT_EN && m_active && cmd_rdy_UART && (cmd_UART[15:12] == 4'hF);
    endfunction

    // First half of a cycle: compare DUT outputs with the model at negedge.
    task automatic tick_a();
        logic [15:0] ex_cmd;
        logic        ex_rdy;
        logic        ex_clr;
        logic [7:0]  ex_resp;
        bit          ab;
        @(negedge clk);
        ab = abort_now();
        if (!m_active) begin
            ex_cmd  = cmd_UART;
            ex_rdy  = cmd_rdy_UART;
            ex_clr  = clr_cmd_rdy;
            ex_resp = 8'hA5;
        end else begin
            ex_cmd  = leg_cmd(sol[m_leg / 2], (m_leg % 2) == 0);
            ex_rdy  = m_wait;
            ex_clr  = ab;
            ex_resp = (ab || (!m_wait && send_resp && m_leg == 47)) ? 8'hA5 : 8'h5A;
        end
        chk("cmd", cmd, ex_cmd);
        chk("cmd_rdy", {15'd0, cmd_rdy}, {15'd0, ex_rdy});
        chk("clr_cmd_rdy_UART", {15'd0, clr_cmd_rdy_UART}, {15'd0, ex_clr});
        chk("resp", {8'd0, resp}, {8'd0, ex_resp});
        chk("mv_indx", {11'd0, mv_indx}, 16'(m_leg / 2));
        if (m_active && cmd_rdy && clr_cmd_rdy) n_cmds++;
        if (int'(mv_indx) > max_idx) max_idx = int'(mv_indx);
    endtask

    // Second half: advance the model with this cycle's inputs, then move on.
    task automatic tick_b();
        bit ab;
        ab = abort_now();
        if (rst) begin
            m_active = 1'b0; m_leg = 0; m_wait = 1'b1;
        end else if (!m_active) begin
            if (start_tour) begin
                m_active = 1'b1; m_leg = 0; m_wait = 1'b1;
            end
        end else if (ab) begin
            m_active = 1'b0; m_leg = 0; m_wait = 1'b1;
        end else if (m_wait) begin
            if (clr_cmd_rdy) m_wait = 1'b0;
        end else if (send_resp) begin
            if (m_leg == 47) m_active = 1'b0;
            else begin m_leg++; m_wait = 1'b1; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        tick_a();
        tick_b();
    endtask

    task automatic new_solution();
        for (int i = 0; i < 24; i++) sol[i] = 8'(1 << $urandom_range(0, 7));
    endtask

    // Drives a cmd_proc-like responder until the tour ends or stop_leg is
    // reached in its completion wait. rnd selects random accept/response
    // timing (including same-cycle clr_cmd_rdy and send_resp).
    task automatic run_tour(input bit do_start, input int acc, input int rsp,
                            input int stop_leg, input bit rnd, input bit lit);
        int wc = 0;
        int guard = 0;
        if (do_start) begin
            start_tour = 1'b1;
            tick();
            start_tour = 1'b0;
        end
        while (m_active && guard < 4000) begin
            if (stop_leg >= 0 && m_leg == stop_leg && !m_wait) break;
            clr_cmd_rdy = 1'b0;
            send_resp   = 1'b0;
            start_tour  = 1'b0;
            if (rnd) begin
                clr_cmd_rdy = ($urandom_range(0, 3) == 0);
                send_resp   = ($urandom_range(0, 4) == 0);
                start_tour  = ($urandom_range(0, 7) == 0);
            end else begin
                wc++;
                if (m_wait ? (wc >= acc) : (wc >= rsp)) begin
                    if (m_wait) clr_cmd_rdy = 1'b1;
                    else        send_resp   = 1'b1;
                    wc = 0;
                end
            end
            cmd_rdy_UART = 1'($urandom_range(0, 1));
            cmd_UART     = {4'($urandom_range(0, 14)), 12'($urandom)};
            tick_a();
            if (lit && m_wait && m_leg < 4) chk("lit_leg_cmd", cmd, lit_tab[m_leg]);
            if (lit && !m_wait && send_resp && m_leg == 47)
                chk("final_resp", {8'd0, resp}, 16'h00A5);
            tick_b();
            guard++;
        end
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b0;
        start_tour   = 1'b0;
        cmd_rdy_UART = 1'b0;
        chk("tour_bound", {15'd0, guard < 4000}, 16'd1);
    endtask

    initial begin
        lit_tab[0] = 16'h2002;
        lit_tab[1] = 16'h3BF1;
        lit_tab[2] = 16'h27F2;
        lit_tab[3] = 16'h33F1;

        new_solution();
        sol[0] = 8'h01;
        sol[1] = 8'h10;

        // Pin the leg model against hand-computed commands.
        chk("model_b0_v", leg_cmd(sol[0], 1'b1), 16'h2002);
        chk("model_b4_h", leg_cmd(sol[1], 1'b0), 16'h33F1);

        @(posedge clk);
        #1;
        tick();
        tick();
        rst = 1'b0;

        // Idle pass-through with random traffic
        for (int i = 0; i < 10; i++) begin
            cmd_UART     = 16'($urandom);
            cmd_rdy_UART = 1'($urandom_range(0, 1));
            clr_cmd_rdy  = 1'($urandom_range(0, 1));
            tick();
        end
        cmd_UART     = 16'h2002;
        cmd_rdy_UART = 1'b1;
        clr_cmd_rdy  = 1'b1;
        tick_a();
        chk("idle_cmd", cmd, 16'h2002);
        chk("idle_cmd_rdy", {15'd0, cmd_rdy}, 16'd1);
        chk("idle_clr_uart", {15'd0, clr_cmd_rdy_UART}, 16'd1);
        chk("idle_resp", {8'd0, resp}, 16'h00A5);
        tick_b();
        cmd_rdy_UART = 1'b0;
        clr_cmd_rdy  = 1'b0;
        tick();

        // Full tour: accept after 3 cycles, respond after 10
        n_cmds  = 0;
        max_idx = 0;
        run_tour(1'b1, 3, 10, -1, 1'b0, 1'b1);
        chk("cmd_count", 16'(n_cmds), 16'd48);
        chk("max_mv_indx", 16'(max_idx), 16'd23);
        cmd_UART = 16'h4321; cmd_rdy_UART = 1'b1;
        tick_a();
        chk("post_tour_passthru", cmd, 16'h4321);
        tick_b();
        cmd_rdy_UART = 1'b0;

        // Reset in HOLD_H of move 7
        new_solution();
        run_tour(1'b1, 2, 4, 15, 1'b0, 1'b0);
        chk("at_move7", {11'd0, mv_indx}, 16'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1;
        tick_a();
        chk("rst_mv_indx", {11'd0, mv_indx}, 16'd0);
        chk("rst_cmd", cmd, 16'h1234);
        chk("rst_cmd_rdy", {15'd0, cmd_rdy}, 16'd1);
        tick_b();
        cmd_rdy_UART = 1'b0;
        tick();

        // Abort command mid-tour
        n_cmds = 0;
        run_tour(1'b1, 2, 3, 9, 1'b0, 1'b0);
        cmd_UART = 16'hF000; cmd_rdy_UART = 1'b1;
        tick_a();
        chk("abort_clr_uart", {15'd0, clr_cmd_rdy_UART}, {15'd0, ABORT_EN});
        chk("abort_resp", {8'd0, resp}, ABORT_EN ? 16'h00A5 : 16'h005A);
        tick_b();
        cmd_UART = 16'h0000; cmd_rdy_UART = 1'b0;
        if (m_active) begin
            run_tour(1'b0, 2, 3, -1, 1'b0, 1'b0);
            chk("no_abort_cmd_count", 16'(n_cmds), 16'd48);
        end
        tick();

        // Randomised tours
        for (int t = 0; t < 3; t++) begin
            new_solution();
            run_tour(1'b1, 0, 0, -1, 1'b1, 1'b0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
